imem_boot_loader: RTL and testbench

Boot-time writer for the instruction memory's second port. Accepts a framed word stream (header, N instruction words, checksum) over a valid/ready handshake. Drives `boot_iaddr`/`boot_idata`/`boot_iwe` into the fetch unit's imem and holds the processor in reset until a complete, checksum-verified image is loaded. Sits between the host/debug link and the pipeline's fetch stage.

---
 rtl/imem_boot_loader.sv | 110 +++++++++++
 tb/tb_imem_boot_loader.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a framed image (header, N words, checksum) and writes it
// into the imem second port, keeping the CPU in reset until the image verifies.
module imem_boot_loader #(
  parameter int          I_DATAWIDTH    = 32,
  parameter int          I_ADDRESSWIDTH = 8,
  parameter logic [15:0] MAGIC          = 16'hB007
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   in_valid,
  input  logic [I_DATAWIDTH-1:0] in_data,
  output logic                   in_ready,
  output logic [31:0]            boot_iaddr,
  output logic [I_DATAWIDTH-1:0] boot_idata,
  output logic                   boot_iwe,
  output logic                   cpu_resetn,
  output logic                   done,
  output logic                   error
);

  localparam int          CW      = I_ADDRESSWIDTH + 1;
  localparam logic [31:0] MAX_LEN = 32'd1 << I_ADDRESSWIDTH;

  typedef enum logic [2:0] {S_HDR, S_LOAD, S_CSUM, S_DONE, S_ERR} state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [CW-1:0]          r_addr;
  logic [CW-1:0]          r_remaining;
  logic [I_DATAWIDTH-1:0] r_sum;
  logic [CW-1:0]          r_iaddr;
  logic [I_DATAWIDTH-1:0] r_idata;
  logic                   r_iwe;

  logic                   w_xfer;
  logic [31:0]            w_hdr_len;
  logic                   w_hdr_ok;
  logic                   w_last_word;

  assign w_xfer      = in_valid & in_ready;
  assign w_hdr_len   = 32'(in_data[15:0]);
  assign w_hdr_ok    = (in_data[31:16] == MAGIC) && (w_hdr_len != 32'd0) && (w_hdr_len <= MAX_LEN);
  assign w_last_word = (r_remaining == CW'(1));

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_HDR;
    else         r_state <= w_next_state;
  end

  // NOTE: default assignment first so every path drives w_next_state and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_HDR:  if (w_xfer) w_next_state = w_hdr_ok ? S_LOAD : S_ERR;
      S_LOAD: if (w_xfer && w_last_word) w_next_state = S_CSUM;
      S_CSUM: if (w_xfer) w_next_state = (in_data == r_sum) ? S_DONE : S_ERR;
      S_DONE: w_next_state = S_DONE;
      S_ERR:  w_next_state = S_ERR;
      default: w_next_state = S_ERR;
    endcase
  end

  always_comb begin
    in_ready   = resetn && (r_state inside {S_HDR, S_LOAD, S_CSUM});
    done       = (r_state == S_DONE);
    error      = (r_state == S_ERR);
    cpu_resetn = (r_state == S_DONE);
  end

  // Address counter is one bit wider than the imem address so a full 2^AW image
  // ends on remaining==0 without the final increment aliasing address 0.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_sum       <= '0;
      r_iaddr     <= '0;
      r_idata     <= '0;
      r_iwe       <= 1'b0;
    end else begin
      r_iwe <= 1'b0;
      if (w_xfer) begin
        unique case (r_state)
          S_HDR: begin
            if (w_hdr_ok) begin
              r_remaining <= w_hdr_len[CW-1:0];
              r_addr      <= '0;
              r_sum       <= '0;
            end
          end
          S_LOAD: begin
            r_iwe       <= 1'b1;
            r_iaddr     <= r_addr;
            r_idata     <= in_data;
            r_sum       <= r_sum + in_data;
            r_addr      <= r_addr + CW'(1);
            r_remaining <= r_remaining - CW'(1);
          end
          default: ;
        endcase
      end
    end
  end

  assign boot_iaddr = 32'(r_iaddr);
  assign boot_idata = r_idata;
  assign boot_iwe   = r_iwe;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: vector table, hand-written timing
// sequences, and randomized frames checked against a frame-level reference model.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic [31:0] boot_iaddr;
  logic [31:0] boot_idata;
  logic        boot_iwe;
  logic        cpu_resetn;
  logic        done;
  logic        error;

  imem_boot_loader #(.I_DATAWIDTH(32), .I_ADDRESSWIDTH(8), .MAGIC(16'hB007)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .boot_iaddr (boot_iaddr),
    .boot_idata (boot_idata),
    .boot_iwe   (boot_iwe),
    .cpu_resetn (cpu_resetn),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] stream_q[$];
  logic [63:0] obs_q[$];
  logic [63:0] exp_q[$];

  // Write monitor samples mid-cycle, away from the active edge.
  always @(negedge clk) if (boot_iwe === 1'b1) obs_q.push_back({boot_iaddr, boot_idata});

  typedef struct {
    int               len;
    logic [5:0][31:0] w;
    bit               exp_done;
    bit               exp_err;
    int               exp_nwr;
  } vec_t;

  vec_t vecs[6];

  function automatic vec_t mk(input int len, input logic [31:0] a, b, c, d, e, f,
                              input bit dn, input bit er, input int nw);
    vec_t v;
    v.len = len;
    v.w[0] = a; v.w[1] = b; v.w[2] = c; v.w[3] = d; v.w[4] = e; v.w[5] = f;
    v.exp_done = dn; v.exp_err = er; v.exp_nwr = nw;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_iwe"},    boot_iwe,   0);
    check({tag, "_iaddr"},  boot_iaddr, 0);
    check({tag, "_idata"},  boot_idata, 0);
    check({tag, "_cpurst"}, cpu_resetn, 0);
    check({tag, "_done"},   done,       0);
    check({tag, "_error"},  error,      0);
    check({tag, "_ready"},  in_ready,   0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("rst");
    resetn = 1'b1;
    #1;
    check("rst_release_ready", in_ready, 1);
  endtask

  // One transfer attempt: valid high across exactly one rising edge.
  task automatic step(input logic [31:0] w);
    in_valid = 1'b1;
    in_data  = w;
    @(posedge clk);
    #1;
  endtask

  task automatic run_stream(input int gap_pct, output int acc);
    obs_q.delete();
    acc = 0;
    foreach (stream_q[i]) begin
      for (int g = 0; g < 3 && gap_pct > 0 && $urandom_range(99) < gap_pct; g++) begin
        in_valid = 1'b0;
        in_data  = $urandom;
        @(posedge clk);
        #1;
      end
      if (!in_ready) break;
      step(stream_q[i]);
      acc++;
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Frame-level reference: interprets stream_q by the framing rules directly.
  task automatic model_stream(output int e_acc, output bit e_done, output bit e_err);
    logic [31:0] hdr;
    logic [31:0] sum;
    int n;
    exp_q.delete();
    e_acc = 0; e_done = 0; e_err = 0; sum = 0;
    if (stream_q.size() == 0) return;
    hdr = stream_q[0];
    n = int'(hdr[15:0]);
    e_acc = 1;
    if (hdr[31:16] != 16'hB007 || n < 1 || n > 256) begin
      e_err = 1;
      return;
    end
    for (int k = 0; k < n && k + 1 < stream_q.size(); k++) begin
      exp_q.push_back({32'(k), stream_q[k+1]});
      sum += stream_q[k+1];
      e_acc++;
    end
    if (stream_q.size() > n + 1) begin
      e_acc++;
      if (stream_q[n+1] == sum) e_done = 1;
      else                      e_err  = 1;
    end
  endtask

  task automatic check_against_model(input string tag, input int acc);
    int e_acc;
    bit e_done, e_err;
    model_stream(e_acc, e_done, e_err);
    check({tag, "_accepted"}, acc,        e_acc);
    check({tag, "_done"},     done,       e_done);
    check({tag, "_error"},    error,      e_err);
    check({tag, "_cpurst"},   cpu_resetn, e_done);
    check({tag, "_ready"},    in_ready,   !(e_done || e_err));
    check({tag, "_nwrites"},  obs_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
      check({tag, "_write"}, obs_q[k], exp_q[k]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    vecs[0] = mk(5, 32'hB0070003, 32'h11, 32'h22, 32'h33, 32'h66, 0, 1, 0, 3);
    vecs[1] = mk(1, 32'hDEAD0003, 0, 0, 0, 0, 0, 0, 1, 0);
    vecs[2] = mk(4, 32'hB0070002, 32'h5, 32'h7, 32'hD, 0, 0, 0, 1, 2);
    vecs[3] = mk(1, 32'hB0070000, 0, 0, 0, 0, 0, 0, 1, 0);
    vecs[4] = mk(3, 32'hB0070101, 32'h1, 32'h2, 0, 0, 0, 0, 1, 0);
    vecs[5] = mk(3, 32'hB0070001, 32'hAB, 32'hAB, 0, 0, 0, 1, 0, 1);

    // Values while reset is held.
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("por");
    resetn = 1'b1;

    // Nominal load, valid held high: cycle-exact write and done timing.
    do_reset();
    begin
      logic [31:0] nw[5];
      nw = '{32'hB0070003, 32'h11, 32'h22, 32'h33, 32'h66};
      for (int i = 0; i < 5; i++) begin
        step(nw[i]);
        if (i >= 1 && i <= 3) begin
          check("nom_iwe",   boot_iwe,   1);
          check("nom_iaddr", boot_iaddr, i - 1);
          check("nom_idata", boot_idata, nw[i]);
          check("nom_done_early", done, 0);
        end else begin
          check("nom_iwe_idle", boot_iwe, 0);
        end
      end
      in_valid = 1'b0;
      check("nom_done",   done,       1);
      check("nom_cpurst", cpu_resetn, 1);
      check("nom_ready",  in_ready,   0);
      check("nom_error",  error,      0);
    end

    // Bad header: error exactly one cycle after the header transfer.
    do_reset();
    step(32'hDEAD0003);
    in_valid = 1'b0;
    check("badhdr_error", error, 1);
    check("badhdr_iwe",   boot_iwe, 0);
    check("badhdr_ready", in_ready, 0);

    // Vector table.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      stream_q.delete();
      for (int k = 0; k < vecs[i].len; k++) stream_q.push_back(vecs[i].w[k]);
      run_stream(0, acc);
      check("vec_done",    done,       vecs[i].exp_done);
      check("vec_error",   error,      vecs[i].exp_err);
      check("vec_cpurst",  cpu_resetn, vecs[i].exp_done);
      check("vec_ready",   in_ready,   !(vecs[i].exp_done || vecs[i].exp_err));
      check("vec_nwrites", obs_q.size(), vecs[i].exp_nwr);
      for (int k = 0; k < obs_q.size() && k < vecs[i].exp_nwr; k++)
        check("vec_write", obs_q[k], {32'(k), vecs[i].w[k+1]});
    end

    // Stall mid-LOAD: outputs hold, then load resumes at the next address.
    do_reset();
    step(32'hB0070004);
    step(32'h1);
    step(32'h2);
    check("stall_pre_iaddr", boot_iaddr, 1);
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("stall_iwe",   boot_iwe,   0);
      check("stall_iaddr", boot_iaddr, 1);
      check("stall_idata", boot_idata, 2);
    end
    step(32'h3);
    check("stall_resume_iwe",   boot_iwe,   1);
    check("stall_resume_iaddr", boot_iaddr, 2);
    step(32'h4);
    check("stall_resume_iaddr2", boot_iaddr, 3);
    step(32'd10);
    in_valid = 1'b0;
    check("stall_done", done, 1);

    // Reset mid-LOAD, then a fresh single-word image.
    do_reset();
    step(32'hB0070004);
    step(32'hA);
    step(32'hB);
    resetn = 1'b0;
    in_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      check_reset_values("midrst");
    end
    resetn = 1'b1;
    #1;
    step(32'hB0070001);
    check("midrst_hdr_iwe", boot_iwe, 0);
    step(32'hAB);
    check("midrst_iwe",   boot_iwe,   1);
    check("midrst_iaddr", boot_iaddr, 0);
    check("midrst_idata", boot_idata, 32'hAB);
    step(32'hAB);
    in_valid = 1'b0;
    check("midrst_done",   done,       1);
    check("midrst_cpurst", cpu_resetn, 1);

    // Full 256-word image with gaps; checksum wraps modulo 2^32.
    do_reset();
    stream_q.delete();
    stream_q.push_back(32'hB0070100);
    for (int k = 0; k < 256; k++) stream_q.push_back(32'hFFFFFFFF);
    stream_q.push_back(32'hFFFFFF00);
    run_stream(30, acc);
    check_against_model("full", acc);
    check("full_done_const", done, 1);
    check("full_last_addr", obs_q.size() > 0 ? obs_q[obs_q.size()-1][63:32] : 32'hDEAD, 255);

    // Randomized frames against the reference model.
    for (int it = 0; it < 40; it++) begin
      int n, kind;
      logic [31:0] sum, w;
      n = $urandom_range(1, 12);
      kind = $urandom_range(0, 9);
      sum = 0;
      stream_q.delete();
      case (kind)
        0: stream_q.push_back({16'(16'hB007 ^ 16'($urandom_range(1, 65535))), 16'(n)});
        3: stream_q.push_back({16'hB007, ($urandom_range(1) != 0) ? 16'd0 : 16'($urandom_range(257, 400))});
        default: stream_q.push_back({16'hB007, 16'(n)});
      endcase
      for (int k = 0; k < n; k++) begin
        w = $urandom;
        stream_q.push_back(w);
        sum += w;
      end
      if (kind == 1)      stream_q.push_back(sum ^ 32'($urandom_range(1, 255)));
      else if (kind != 2) stream_q.push_back(sum);
      do_reset();
      run_stream(25, acc);
      check_against_model("rand", acc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
